// File: rtl/mpu_loader_pkg.sv
// mpu_loader_pkg
// Shared definitions for the MPU program loader: FSM state encoding, frame
// command bytes and the default RAM geometry.
package mpu_loader_pkg;

   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 8;

   localparam logic [7:0] CMD_LOAD     = 8'hA5;
   localparam logic [7:0] CMD_LOAD_RUN = 8'h5A;
   localparam logic [7:0] CMD_RUN      = 8'h3C;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_ADDR = 3'd1,
      S_GET_LEN  = 3'd2,
      S_DATA     = 3'd3,
      S_CSUM     = 3'd4,
      S_RUN      = 3'd5
   } state_e;

   function automatic logic is_load_cmd(input logic [7:0] b);
      return (b == CMD_LOAD) || (b == CMD_LOAD_RUN);
   endfunction

endpackage

// File: rtl/mpu_loader.sv
// mpu_loader
// Byte-stream program loader for the soft MPU. Receives framed bytes
// (CMD, ADDR, LEN, data..., CSUM) over valid/ready, writes the data bytes into
// the MPU RAM through a registered write port, verifies the XOR checksum and
// controls the MPU reset/start pins.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader can accept a byte (registered, independent of in_valid)
//   mem_we     RAM write strobe, one cycle per data byte
//   mem_addr   RAM write address
//   mem_wdata  RAM write data
//   cpu_rst    MPU reset, active-high
//   cpu_start  one-cycle MPU start pulse
//   busy       frame in progress (state != IDLE)
//   done       sticky: last frame passed its checksum
//   err        sticky: last frame failed its checksum
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a command byte; unknown bytes are dropped
// GET_ADDR | waiting for the start address
// GET_LEN  | waiting for the byte count
// DATA     | writing payload bytes, count-down to the last one
// CSUM     | waiting for the checksum byte
// RUN      | one cycle: release MPU reset and pulse start, no byte accepted
module mpu_loader
   import mpu_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              cpu_start,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e            state_q, state_d;
   logic              run_q, run_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] csum_q, csum_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              cpu_start_q, cpu_start_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              accept;

   assign accept = in_valid & ready_q;

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      csum_d   = csum_q;
      done_d   = done_q;
      err_d    = err_q;
      cpu_rst_d = cpu_rst_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_load_cmd(in_data[7:0])) begin
                  state_d   = S_GET_ADDR;
                  run_d     = (in_data[7:0] == CMD_LOAD_RUN);
                  done_d    = 1'b0;
                  err_d     = 1'b0;
                  cpu_rst_d = 1'b1;
                  csum_d    = '0;
               end else if (in_data[7:0] == CMD_RUN) begin
                  state_d = S_RUN;
               end
            end
         end
         S_GET_ADDR: begin
            if (accept) begin
               // upper address bits are dropped but still part of the checksum
               ptr_d   = in_data[ADDR_W-1:0];
               csum_d  = csum_q ^ in_data;
               state_d = S_GET_LEN;
            end
         end
         S_GET_LEN: begin
            if (accept) begin
               csum_d = csum_q ^ in_data;
               if (in_data == '0) begin
                  state_d = S_CSUM;
               end else begin
                  cnt_d   = in_data;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               we_d    = 1'b1;
               waddr_d = ptr_q;
               wdata_d = in_data;
               ptr_d   = ptr_q + ADDR_W'(1);
               csum_d  = csum_q ^ in_data;
               if (cnt_q == DATA_W'(1)) begin
                  state_d = S_CSUM;
               end else begin
                  cnt_d = cnt_q - DATA_W'(1);
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (in_data == csum_q) begin
                  done_d  = 1'b1;
                  state_d = run_q ? S_RUN : S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_RUN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so that cpu_start,
      // cpu_rst and in_ready all switch in the RUN cycle itself.
      if (state_d == S_RUN) begin
         cpu_rst_d = 1'b0;
      end
      cpu_start_d = (state_d == S_RUN);
      ready_d     = (state_d != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         run_q       <= 1'b0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         csum_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cpu_rst_q   <= 1'b1;
         cpu_start_q <= 1'b0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cpu_rst_q   <= cpu_rst_d;
         cpu_start_q <= cpu_start_d;
         ready_q     <= ready_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign in_ready  = ready_q;
   assign mem_we    = we_q;
   assign mem_addr  = waddr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rst   = cpu_rst_q;
   assign cpu_start = cpu_start_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mpu_loader.sv
module tb_mpu_loader;
   import mpu_loader_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       mem_we;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_rst;
   logic       cpu_start;
   logic       busy;
   logic       done;
   logic       err;

   mpu_loader #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .cpu_start(cpu_start),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [5:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] pl[$];
   int         start_cnt = 0;
   bit         stall_en = 1'b0;

   // write scoreboard and start-pulse monitor
   wr_t mon_e;
   always @(negedge clk) begin
      if (mem_we) begin
         check_eq("write_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("wr_addr", mem_addr, mon_e.a);
            check_eq("wr_data", mem_wdata, mon_e.d);
         end
      end
      if (cpu_start) begin
         start_cnt++;
         check_eq("start_cpu_rst_low", cpu_rst, 0);
         check_eq("start_in_ready_low", in_ready, 0);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      if (stall_en && ($urandom_range(0, 1) == 1)) begin
         @(negedge clk);
         in_valid = 1'b0;
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("ready_wait_bound", (n < 100), 1);
      @(posedge clk);
   endtask

   // sends a frame using payload pl; csum_ovr < 0 means use the correct checksum
   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input int csum_ovr);
      logic [7:0] cs;
      logic [5:0] p;
      wr_t        w;
      cs = addr ^ 8'(pl.size());
      p  = addr[5:0];
      foreach (pl[i]) begin
         cs  = cs ^ pl[i];
         w.a = p;
         w.d = pl[i];
         exp_q.push_back(w);
         p   = p + 6'd1;
      end
      if (csum_ovr >= 0) cs = 8'(csum_ovr);
      send_byte(cmd);
      send_byte(addr);
      send_byte(8'(pl.size()));
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(cs);
   endtask

   // call right after the last byte of a frame was transferred
   task automatic check_after(input string tag, input logic exp_done, input logic exp_err,
                              input logic exp_run, input int s0);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq({tag, "_done"}, done, exp_done);
      check_eq({tag, "_err"}, err, exp_err);
      check_eq({tag, "_start"}, cpu_start, exp_run);
      check_eq({tag, "_cpu_rst"}, cpu_rst, !exp_run);
      check_eq({tag, "_in_ready"}, in_ready, !exp_run);
      @(negedge clk);
      check_eq({tag, "_start_fall"}, cpu_start, 0);
      check_eq({tag, "_cpu_rst_hold"}, cpu_rst, !exp_run);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_ready_back"}, in_ready, 1);
      check_eq({tag, "_start_pulses"}, start_cnt - s0, exp_run);
      check_eq({tag, "_writes_pending"}, exp_q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_in_ready"}, in_ready, 0);
      check_eq({tag, "_mem_we"}, mem_we, 0);
      check_eq({tag, "_mem_addr"}, mem_addr, 0);
      check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
      check_eq({tag, "_cpu_rst"}, cpu_rst, 1);
      check_eq({tag, "_cpu_start"}, cpu_start, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_err"}, err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      wr_t w;

      // reset
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b1;
      @(negedge clk);
      check_eq("ready_after_reset", in_ready, 1);

      // load only, no start
      s0 = start_cnt;
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(CMD_LOAD, 8'h10, -1);
      check_after("load", 1, 0, 0, s0);

      // load and run with address wrap
      s0 = start_cnt;
      pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_frame(CMD_LOAD_RUN, 8'h3E, -1);
      check_after("load_run", 1, 0, 1, s0);

      // bad checksum: data still written, no start
      s0 = start_cnt;
      pl = '{8'hFF};
      send_frame(CMD_LOAD_RUN, 8'h00, 0);
      check_after("bad_csum", 0, 1, 0, s0);

      // unknown bytes ignored, then run-only command
      send_byte(8'h00);
      send_byte(8'h77);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("ignored_busy", busy, 0);
      check_eq("ignored_err", err, 1);
      check_eq("ignored_done", done, 0);
      s0 = start_cnt;
      send_byte(CMD_RUN);
      check_after("run_only", 0, 1, 1, s0);

      // stalled stream, upper address bits set
      stall_en = 1'b1;
      s0 = start_cnt;
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(CMD_LOAD, 8'hD0, -1);
      check_after("stall_load", 1, 0, 0, s0);
      s0 = start_cnt;
      pl = '{8'h01, 8'h80, 8'h7F, 8'hC3, 8'h5A};
      send_frame(CMD_LOAD_RUN, 8'h3D, -1);
      check_after("stall_load_run", 1, 0, 1, s0);
      s0 = start_cnt;
      pl = {};
      send_frame(CMD_LOAD, 8'h05, -1);
      check_after("len_zero", 1, 0, 0, s0);
      stall_en = 1'b0;

      // reset after the 2nd data byte of a 5-byte frame
      send_byte(CMD_LOAD);
      send_byte(8'h20);
      send_byte(8'h05);
      w.a = 6'h20; w.d = 8'h9A; exp_q.push_back(w);
      w.a = 6'h21; w.d = 8'h9B; exp_q.push_back(w);
      send_byte(8'h9A);
      send_byte(8'h9B);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_reset("mid_reset");
      check_eq("mid_reset_writes", exp_q.size(), 0);
      rst = 1'b1;

      // long frame after reset: LEN > 64 wraps and overwrites
      s0 = start_cnt;
      pl = {};
      for (int i = 0; i < 70; i++) pl.push_back(8'($urandom_range(0, 255)));
      send_frame(CMD_LOAD_RUN, 8'h30, -1);
      check_after("after_reset_long", 1, 0, 1, s0);

      repeat (3) @(negedge clk);
      check_eq("final_writes_pending", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mpu_loader.md
# mpu_loader

Byte-stream program loader for the soft MPU. Accepts framed bytes over a valid/ready input, writes them into the MPU's 64 x 8 unified RAM through a dedicated write port, verifies an XOR checksum, and holds the MPU in reset until a good load-and-run frame completes. It then releases reset and pulses `start`. It sits between the host interface and the `top` CPU's `rst`/`start` pins and RAM write port, and replaces testbench preloading of RAM.

## Interface
- `ADDR_W`, 6: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 8: RAM word and stream byte width.
- `clk`  in  1  Rising-edge clock.
- `rst`  in  1  Synchronous, active-low reset; `rst`=0 at a rising edge resets the block.
- `in_data`  in  8  Stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  Loader can accept a byte. A byte transfers on a clock edge where `in_valid` and `in_ready` are both 1.
- `mem_we`  out  1  RAM write strobe.
- `mem_addr`  out  6  RAM write address.
- `mem_wdata`  out  8  RAM write data.
- `cpu_rst`  out  1  MPU reset, active-high, as expected by `top`.
- `cpu_start`  out  1  One-cycle MPU start pulse.
- `busy`  out  1  A frame is in progress (any state other than IDLE).
- `done`  out  1  Sticky: the last frame passed its checksum.
- `err`  out  1  Sticky: the last frame failed its checksum.

## Operation
- Frame format: `CMD`, `ADDR`, `LEN`, `LEN` data bytes, `CSUM`.
- `CMD` values:
  - 0xA5: load only.
  - 0x5A: load, then run.
  - 0x3C: run only. The frame is the single `CMD` byte.
- Any other byte received in IDLE is discarded. No flags change.
- `CSUM` must equal the XOR of `ADDR`, `LEN` and all data bytes.
- States: IDLE, GET_ADDR, GET_LEN, DATA, CSUM, RUN.
  - IDLE: on 0xA5 or 0x5A go to GET_ADDR, latch the run flag, clear `done`/`err`, set `cpu_rst`=1. On 0x3C go to RUN.
  - GET_ADDR: latch the write pointer from `ADDR[5:0]`; `ADDR[7:6]` are ignored but still included in the checksum.
  - GET_LEN: `LEN`=0 goes to CSUM; otherwise latch the count and go to DATA.
  - DATA: each accepted byte is written at the pointer. The pointer then increments modulo 64, so a write at 63 is followed by one at 0. After the last byte, go to CSUM.
  - CSUM: on a match set `done` and go to RUN if the run flag is set, else to IDLE. On a mismatch set `err` and go to IDLE. `cpu_rst` stays 1 in both cases.
  - RUN: `cpu_rst`=0 and `cpu_start`=1 for exactly one cycle, then IDLE. `cpu_rst` stays 0 afterwards until the next load `CMD`.
- Bytes already written to RAM are not rolled back on a checksum failure.
- `LEN` greater than 64 is legal. The pointer wraps, and later bytes overwrite earlier ones.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `cpu_start`=0, `busy`=0, `done`=0, `err`=0. State is IDLE.
- `in_ready`:
  - 1 in IDLE, GET_ADDR, GET_LEN, DATA and CSUM, from the first cycle after reset is released.
  - 0 in RUN.
- `in_ready` does not depend combinationally on `in_valid`. Stalls (`in_valid`=0) are allowed between any two bytes, of any length.
- Writes are registered. `mem_we`, `mem_addr` and `mem_wdata` are valid in the cycle after the data byte is accepted. `mem_we` is high for exactly one cycle per byte, and back-to-back writes are allowed.
- `done`/`err` update in the cycle after `CSUM` is accepted.
- `cpu_start` rises in that same cycle and falls one cycle later.
- Reset asserted mid-frame: the frame is abandoned and all outputs return to their reset values the next cycle. Any write issued in the reset cycle is suppressed.

## Structure
- Shared package `mpu_loader_pkg`:
  - state enum;
  - `CMD_LOAD`=8'hA5, `CMD_LOAD_RUN`=8'h5A, `CMD_RUN`=8'h3C;
  - `ADDR_W`/`DATA_W` defaults.
- Single module with no sub-modules. The pointer, count and XOR accumulator are inline registers.

## Test plan
- Frame A5,10,03,11,22,33,CSUM=0x10^0x03^0x11^0x22^0x33 -> writes RAM[16]=11, [17]=22, [18]=33; `done`=1; `cpu_rst` stays 1; `cpu_start` never pulses.
- Frame 5A,3E,04,AA,BB,CC,DD with a good `CSUM` -> writes at 62, 63, 0, 1 (wrap); `done`=1; `cpu_rst` falls and `cpu_start`=1 for exactly one cycle; `top` begins executing.
- Frame 5A,00,01,FF,`CSUM`=0x00 (bad) -> RAM[0]=FF is written; `err`=1, `done`=0; no start; `cpu_rst` stays 1.
- Stream 00,77,3C -> 00 and 77 are ignored with flags unchanged; 3C drops `cpu_rst` and pulses `cpu_start` once; `in_ready`=0 for that one cycle.
- Good frame with `in_valid` toggling randomly mid-frame, plus `LEN`=0 frame A5,05,00,05 -> results identical to the unstalled case; the `LEN`=0 frame produces no writes and `done`=1.
- `rst`=0 asserted after the 2nd data byte of a 5-byte frame -> exactly 2 writes occur; all outputs take their reset values; the next good frame loads correctly.
